hir_matmul_kernel: RTL and testbench
====================================

Name: hir_matmul_kernel

Overview:
- Sequential N×N integer matrix-multiply kernel, C = A × B.
- Reads A through memory port v0 and B through memory port v1; writes C through memory port v2.
- All three memories are external, single-port, row-major (element [r][c] at address r*N+c), with 1-cycle read latency.
- Started by a one-cycle pulse on tstart; runs to completion with no backpressure.

Parameters:
- N, 16: matrix dimension. N*N must fit in ADDR_W bits.
- ADDR_W, 8: address width of all three ports.
- DATA_W, 32: element and accumulator width.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: synchronous, active-high reset.
- v0_addr, output, ADDR_W: A read address.
- v0_rd_en, output, 1: A read enable.
- v0_rd_data, input, DATA_W: A read data, valid in the cycle after v0_rd_en.
- v1_addr, output, ADDR_W: B read address.
- v1_rd_en, output, 1: B read enable.
- v1_rd_data, input, DATA_W: B read data, valid in the cycle after v1_rd_en.
- v2_addr, output, ADDR_W: C write address.
- v2_wr_en, output, 1: C write enable.
- v2_wr_data, output, DATA_W: C write data.
- tstart, input, 1: start pulse.

Behaviour:
- One clock. Reset is synchronous and active-high. All outputs are registered.
- Reset values: all addresses 0, all enables 0, v2_wr_data 0, state IDLE, loop counters 0, accumulator 0.
- States: IDLE, ISSUE, DRAIN, WRITE.
- IDLE → ISSUE when tstart = 1 at a rising edge; i, j, k and acc are cleared.
- tstart is ignored in every state other than IDLE.
- Loop order: i (rows of C) outermost, then j (columns of C), then k (reduction) innermost; all counters run 0..N-1.
- ISSUE lasts N cycles. In cycle k:
  - v0_rd_en = v1_rd_en = 1.
  - v0_addr = i*N+k, v1_addr = k*N+j.
- Accumulation: in every cycle where the data for a read issued in the previous cycle is present, acc ← acc + v0_rd_data*v1_rd_data.
  - The product is truncated to the low DATA_W bits; the sum wraps modulo 2^DATA_W (no saturation; operands unsigned/two's complement, bit-identical).
  - The first product of each element replaces acc (acc starts from 0).
- ISSUE → DRAIN after k = N-1. DRAIN lasts 1 cycle: enables low, last product accumulated.
- DRAIN → WRITE. WRITE lasts 1 cycle:
  - v2_wr_en = 1, v2_addr = i*N+j, v2_wr_data = final acc.
- After WRITE, advance j (and i on j wrap) and return to ISSUE. After the WRITE for i = j = N-1, go to IDLE.
- Per-element latency is N+2 cycles. Total run is N*N*(N+2) cycles (4608 for N = 16).
- With tstart sampled at edge E0, cycle c is the cycle following edge E(c-1):
  - First read is in cycle 1.
  - First write is in cycle N+2.
  - Last write is in cycle N*N*(N+2).
  - A new tstart is accepted from the edge after the last write.
- Outside ISSUE/WRITE, enables are 0. Addresses and write data hold their last value; they are don't-care for the memories.
- rst asserted mid-run: state returns to IDLE at that edge; enables are 0 in the next cycle; no partial write is issued.

Optional Feature:
- Macro HIR_MATMUL_DONE_EN.
- When defined: extra output port done (1 bit, reset 0), pulsed high for exactly one cycle in the cycle immediately after the final WRITE.
- When undefined: no done port and no related logic; the port list is exactly as above.

Test Plan:
- Memory model returns rd_data = address (registered, 1-cycle latency); pulse tstart → C[0][0]=19840 at v2_addr 0, C[0][1]=19960 at addr 1, C[1][0]=50560 at addr 16, C[15][15]=540040 at addr 255; exactly 256 writes, each address once, in ascending order.
- Cycle timing, same run: cycle 1 has v0_addr=0, v1_addr=0; cycle 2 has v0_addr=1, v1_addr=16; first v2_wr_en is in cycle 18; consecutive writes are exactly 18 cycles apart; last write is in cycle 4608.
- tstart pulsed again at cycle 100 → ignored; the write sequence is unchanged.
- A = all 0xFFFFFFFF, B = all 2 → every C element = 0xFFFFFFE0 (wrap-around).
- rst asserted at cycle 500 → all enables low from cycle 501; a new tstart restarts at v0_addr=0, v1_addr=0, and C[0][0] is correct.
- With HIR_MATMUL_DONE_EN: done high only in cycle 4609; stays 0 throughout a run that is aborted by rst.

Source files
------------

// File: rtl/hir_matmul_kernel.sv
// Sequential NxN integer matrix multiply C = A x B over three single-port memories (v0=A, v1=B, v2=C).
// Latency: N+2 cycles per C element, N*N*(N+2) cycles per run; first read one cycle after tstart.
// No backpressure: runs to completion once started; tstart ignored while busy. Optional done pulse: HIR_MATMUL_DONE_EN.
module hir_matmul_kernel #(
  parameter int N      = 16,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] v0_addr,
  output logic              v0_rd_en,
  input  logic [DATA_W-1:0] v0_rd_data,
  output logic [ADDR_W-1:0] v1_addr,
  output logic              v1_rd_en,
  input  logic [DATA_W-1:0] v1_rd_data,
  output logic [ADDR_W-1:0] v2_addr,
  output logic              v2_wr_en,
  output logic [DATA_W-1:0] v2_wr_data,
  input  logic              tstart
`ifdef HIR_MATMUL_DONE_EN
  ,
  output logic              done
`endif
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, WRITE} state_t;

  state_t            state;
  logic [CW-1:0]     i, j, k;
  logic [CW-1:0]     k_inc, ni, nj;
  logic              last_i, last_j, last_k;
  logic [DATA_W-1:0] acc, acc_next;
  // rd_vld: memory data for a read issued last cycle is on the rd_data buses now.
  // rd_first: that data belongs to k=0, so it starts a fresh sum.
  logic              rd_vld, rd_first;

  // Row-major linear address r*N+c.
  function automatic logic [ADDR_W-1:0] lin(input logic [CW-1:0] r, input logic [CW-1:0] c);
    return ADDR_W'(32'(r) * N + 32'(c));
  endfunction

  // Loop-counter wrap detection, next-element indices and the multiply-accumulate.
  always_comb begin
    last_i   = (i == CW'(N - 1));
    last_j   = (j == CW'(N - 1));
    last_k   = (k == CW'(N - 1));
    k_inc    = k + CW'(1);
    nj       = last_j ? '0 : j + CW'(1);
    ni       = last_j ? i + CW'(1) : i;
    acc_next = (rd_first ? '0 : acc) + v0_rd_data * v1_rd_data;
  end

  // Control FSM with registered memory-port outputs and the accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      i          <= '0;
      j          <= '0;
      k          <= '0;
      acc        <= '0;
      rd_vld     <= 1'b0;
      rd_first   <= 1'b0;
      v0_addr    <= '0;
      v0_rd_en   <= 1'b0;
      v1_addr    <= '0;
      v1_rd_en   <= 1'b0;
      v2_addr    <= '0;
      v2_wr_en   <= 1'b0;
      v2_wr_data <= '0;
`ifdef HIR_MATMUL_DONE_EN
      done       <= 1'b0;
`endif
    end else begin
      rd_vld   <= (state == ISSUE);
      rd_first <= (state == ISSUE) && (k == '0);
      if (rd_vld) acc <= acc_next;
`ifdef HIR_MATMUL_DONE_EN
      done     <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (tstart) begin
            i        <= '0;
            j        <= '0;
            k        <= '0;
            acc      <= '0;
            v0_rd_en <= 1'b1;
            v1_rd_en <= 1'b1;
            v0_addr  <= '0;
            v1_addr  <= '0;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (last_k) begin
            v0_rd_en <= 1'b0;
            v1_rd_en <= 1'b0;
            state    <= DRAIN;
          end else begin
            k       <= k_inc;
            v0_addr <= lin(i, k_inc);
            v1_addr <= lin(k_inc, j);
          end
        end
        DRAIN: begin
          // The last product arrives now, so the write data is taken straight from acc_next.
          v2_wr_en   <= 1'b1;
          v2_addr    <= lin(i, j);
          v2_wr_data <= acc_next;
          k          <= '0;
          state      <= WRITE;
        end
        WRITE: begin
          v2_wr_en <= 1'b0;
          i        <= ni;
          j        <= nj;
          if (last_i && last_j) begin
            state <= IDLE;
`ifdef HIR_MATMUL_DONE_EN
            done  <= 1'b1;
`endif
          end else begin
            v0_rd_en <= 1'b1;
            v1_rd_en <= 1'b1;
            v0_addr  <= lin(ni, '0);
            v1_addr  <= lin('0, nj);
            state    <= ISSUE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hir_matmul_kernel.sv
// Scoreboard bench for hir_matmul_kernel: randomized and directed matrices, stray tstart, mid-run reset.
// Expected C values come from a plain triple-loop matrix product; a negedge monitor checks every cycle.
// Memories are modelled as arrays with registered 1-cycle read data.
module tb_hir_matmul_kernel;

  localparam int N      = 16;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int TOTAL  = N * N * (N + 2);

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] v0_addr, v1_addr, v2_addr;
  logic              v0_rd_en, v1_rd_en, v2_wr_en;
  logic [DATA_W-1:0] v0_rd_data, v1_rd_data, v2_wr_data;
  logic              tstart;
`ifdef HIR_MATMUL_DONE_EN
  logic              done;
`endif

  hir_matmul_kernel #(.N(N), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .v0_addr    (v0_addr),
    .v0_rd_en   (v0_rd_en),
    .v0_rd_data (v0_rd_data),
    .v1_addr    (v1_addr),
    .v1_rd_en   (v1_rd_en),
    .v1_rd_data (v1_rd_data),
    .v2_addr    (v2_addr),
    .v2_wr_en   (v2_wr_en),
    .v2_wr_data (v2_wr_data),
`ifdef HIR_MATMUL_DONE_EN
    .done       (done),
`endif
    .tstart     (tstart)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int                cyc;
  } wr_t;

  logic [DATA_W-1:0] ma [N*N];
  logic [DATA_W-1:0] mb [N*N];
  wr_t               q [$];
  int                n_vec = 0;
  int                n_err = 0;
  int                edges = 0;
  int                e0 = 1 << 30;
  bit                run_active = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edges <= edges + 1;

  // Memory models: registered read data, one cycle after the enable.
  always @(posedge clk) begin
    if (v0_rd_en) v0_rd_data <= ma[v0_addr];
    if (v1_rd_en) v1_rd_data <= mb[v1_addr];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: plain matrix product with 32-bit wrap, queued in write order.
  task automatic push_expected();
    wr_t w;
    logic [DATA_W-1:0] sum;
    for (int e = 0; e < N * N; e++) begin
      sum = '0;
      for (int kk = 0; kk < N; kk++)
        sum = sum + ma[(e / N) * N + kk] * mb[kk * N + (e % N)];
      w.addr = ADDR_W'(e);
      w.data = sum;
      w.cyc  = (e + 1) * (N + 2);
      q.push_back(w);
    end
  endtask

  // Monitor: per-cycle read schedule, done pulse, and write scoreboard.
  always @(negedge clk) begin
    int c, e, off;
    wr_t w;
    c = edges - e0 + 1;
    if (!rst && run_active && c >= 1 && c <= TOTAL + 1) begin
      e   = (c - 1) / (N + 2);
      off = (c - 1) % (N + 2);
      if (e < N * N && off < N) begin
        chk("v0_rd_en", v0_rd_en, 1);
        chk("v1_rd_en", v1_rd_en, 1);
        chk("v0_addr", v0_addr, (e / N) * N + off);
        chk("v1_addr", v1_addr, off * N + (e % N));
      end else begin
        chk("v0_rd_en_idle", v0_rd_en, 0);
        chk("v1_rd_en_idle", v1_rd_en, 0);
      end
`ifdef HIR_MATMUL_DONE_EN
      chk("done_run", done, (c == TOTAL + 1) ? 1 : 0);
`endif
    end else if (!rst) begin
`ifdef HIR_MATMUL_DONE_EN
      chk("done_quiet", done, 0);
`endif
    end
    if (!rst && v2_wr_en) begin
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write: got write addr 0x%0h, expected no write (t=%0t)", v2_addr, $time);
      end else begin
        w = q.pop_front();
        chk("v2_addr", v2_addr, w.addr);
        chk("v2_wr_data", v2_wr_data, w.data);
        chk("write_cycle", c, w.cyc);
      end
    end
  end

  task automatic goto_cycle(input int c);
    while (edges - e0 + 1 < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_run();
    @(posedge clk);
    #1;
    push_expected();
    e0         = edges + 1;
    run_active = 1;
    tstart     = 1'b1;
    @(posedge clk);
    #1;
    tstart = 1'b0;
  endtask

  task automatic wait_done();
    for (int t = 0; t < TOTAL + 100 && q.size() > 0; t++) @(posedge clk);
    if (q.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL run_timeout: got %0d writes outstanding, expected 0", q.size());
      q.delete();
    end
    repeat (4) @(posedge clk);
    #1;
    run_active = 0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst    = 1'b1;
    tstart = 1'b0;
    for (int x = 0; x < N * N; x++) begin
      ma[x] = DATA_W'(x);
      mb[x] = DATA_W'(x);
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_v0_addr", v0_addr, 0);
    chk("rst_v1_addr", v1_addr, 0);
    chk("rst_v2_addr", v2_addr, 0);
    chk("rst_v0_rd_en", v0_rd_en, 0);
    chk("rst_v1_rd_en", v1_rd_en, 0);
    chk("rst_v2_wr_en", v2_wr_en, 0);
    chk("rst_v2_wr_data", v2_wr_data, 0);

    // Run 1: data = address, plus a stray tstart mid-run that must be ignored.
    start_run();
    goto_cycle(100);
    tstart = 1'b1;
    @(posedge clk);
    #1;
    tstart = 1'b0;
    wait_done();

    // Run 2: all-ones times two wraps every element to 0xFFFFFFE0.
    for (int x = 0; x < N * N; x++) begin
      ma[x] = '1;
      mb[x] = 32'd2;
    end
    start_run();
    wait_done();

    // Run 3: random operands.
    for (int x = 0; x < N * N; x++) begin
      ma[x] = $urandom;
      mb[x] = $urandom;
    end
    start_run();
    wait_done();

    // Run 4: aborted by reset at cycle 500; no further activity afterwards.
    start_run();
    goto_cycle(500);
    rst        = 1'b1;
    run_active = 0;
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      chk("abort_v0_rd_en", v0_rd_en, 0);
      chk("abort_v1_rd_en", v1_rd_en, 0);
      chk("abort_v2_wr_en", v2_wr_en, 0);
    end

    // Run 5: restart after abort with fresh random small operands.
    for (int x = 0; x < N * N; x++) begin
      ma[x] = DATA_W'($urandom_range(0, 1000));
      mb[x] = DATA_W'($urandom_range(0, 1000));
    end
    start_run();
    wait_done();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
